// File: rtl/stage_sequencer.sv
// stage_sequencer: control FSM stepping each instruction through fetch/decode/exec/[mem]/write.
// Optional stalled-stage watchdog is built when SEQ_WATCHDOG_EN is defined.
`default_nettype none

module stage_sequencer #(
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned WDOG_CYCLES = 1024,
   parameter int unsigned WDOG_W      = 11
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic             halt_req,
   input  logic             need_mem,
   input  logic             fetch_done,
   input  logic             decode_done,
   input  logic             exec_done,
   input  logic             mem_done,
   input  logic             write_done,
   output logic             fetch_en,
   output logic             decode_en,
   output logic             exec_en,
   output logic             mem_en,
   output logic             write_en,
   output logic [2:0]       stage,
   output logic             busy,
   output logic             halted,
   output logic [CNT_W-1:0] retired,
   output logic             timeout_err
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_F    = 3'd1;
   localparam logic [2:0] S_D    = 3'd2;
   localparam logic [2:0] S_E    = 3'd3;
   localparam logic [2:0] S_M    = 3'd4;
   localparam logic [2:0] S_W    = 3'd5;
   localparam logic [2:0] S_HALT = 3'd6;
   localparam logic [2:0] S_ERR  = 3'd7;

   if (WDOG_CYCLES >= (64'd1 << WDOG_W)) begin : g_wdog_w_too_small
      $error("WDOG_W cannot hold WDOG_CYCLES");
   end

   logic [2:0]       state_q, state_d;
   logic             entry_q, entry_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             in_stage;
   logic             done_sel;
   logic             accept;
   logic             trap;

   assign in_stage = (state_q >= S_F) && (state_q <= S_W);

   always_comb begin
      done_sel = 1'b0;
      case (state_q)
         S_F:     done_sel = fetch_done;
         S_D:     done_sel = decode_done;
         S_E:     done_sel = exec_done;
         S_M:     done_sel = mem_done;
         S_W:     done_sel = write_done;
         default: done_sel = 1'b0;
      endcase
   end

   // The entry cycle carries the enable pulse; done is only honoured afterwards.
   assign accept = in_stage && !entry_q && done_sel;

`ifdef SEQ_WATCHDOG_EN
   logic [WDOG_W-1:0] wcnt_q, wcnt_d;
   logic              terr_q;

   assign trap = in_stage && !entry_q && !done_sel && (wcnt_q == WDOG_W'(WDOG_CYCLES));

   always_comb begin
      wcnt_d = wcnt_q;
      if (state_d != state_q) begin
         wcnt_d = '0;
      end else if (in_stage && (wcnt_q != WDOG_W'(WDOG_CYCLES))) begin
         wcnt_d = wcnt_q + WDOG_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wcnt_q <= '0;
         terr_q <= 1'b0;
      end else begin
         wcnt_q <= wcnt_d;
         if (trap) begin
            terr_q <= 1'b1;
         end
      end
   end

   assign timeout_err = terr_q;
`else
   assign trap        = 1'b0;
   assign timeout_err = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      retired_d = retired_q;
      case (state_q)
         S_IDLE: begin
            if (halt_req) begin
               state_d = S_HALT;
            end else if (start) begin
               state_d = S_F;
            end
         end
         S_F: if (accept) state_d = S_D;
         S_D: if (accept) state_d = S_E;
         S_E: if (accept) state_d = need_mem ? S_M : S_W;
         S_M: if (accept) state_d = S_W;
         S_W: begin
            if (accept) begin
               retired_d = retired_q + CNT_W'(1);
               state_d   = halt_req ? S_HALT : S_F;
            end
         end
         S_HALT, S_ERR: state_d = state_q;
         default:       state_d = S_IDLE;
      endcase
      if (trap) begin
         state_d = S_ERR;
      end
   end

   assign entry_d = (state_d != state_q) && (state_d >= S_F) && (state_d <= S_W);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= S_IDLE;
         entry_q   <= 1'b0;
         retired_q <= '0;
      end else begin
         state_q   <= state_d;
         entry_q   <= entry_d;
         retired_q <= retired_d;
      end
   end

   assign fetch_en  = entry_q && (state_q == S_F);
   assign decode_en = entry_q && (state_q == S_D);
   assign exec_en   = entry_q && (state_q == S_E);
   assign mem_en    = entry_q && (state_q == S_M);
   assign write_en  = entry_q && (state_q == S_W);
   assign stage     = state_q;
   assign busy      = in_stage;
   assign halted    = (state_q == S_HALT);
   assign retired   = retired_q;

endmodule

`default_nettype wire
